// File: rtl/xnor_neuron_accumulator_pkg.sv
// Shared types and default sizing for the XNOR neuron accumulator.
//   state_t         : FSM state (ACCUM collects beats, HOLD presents a result)
//   CHUNK_BITS_DEF  : default activation/weight bits per beat
//   MAX_CHUNKS_DEF  : default nominal beats per frame
//   ACC_BITS_DEF    : default accumulator / threshold / count width
package xnor_neuron_accumulator_pkg;

  localparam int unsigned CHUNK_BITS_DEF = 8;
  localparam int unsigned MAX_CHUNKS_DEF = 16;
  localparam int unsigned ACC_BITS_DEF   = $clog2(CHUNK_BITS_DEF * MAX_CHUNKS_DEF + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/xnor_neuron_accumulator_if.sv
// Beat-in / result-out bundle of the XNOR neuron accumulator.
//   in_valid/in_ready/in_last/in_data/in_weight : chunk beat stream
//   threshold                                   : compare level, taken on the last beat
//   out_valid/out_ready/out_bit/out_count/out_overflow : result stream
// master = producer of beats and consumer of results; slave = the neuron.
interface xnor_neuron_accumulator_if
  import xnor_neuron_accumulator_pkg::*;
#(
  parameter int unsigned CHUNK_BITS = CHUNK_BITS_DEF,
  parameter int unsigned ACC_BITS   = ACC_BITS_DEF
);

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [CHUNK_BITS-1:0] in_data;
  logic [CHUNK_BITS-1:0] in_weight;
  logic [ACC_BITS-1:0]   threshold;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_bit;
  logic [ACC_BITS-1:0]   out_count;
  logic                  out_overflow;

  modport master (
    output in_valid, in_last, in_data, in_weight, threshold, out_ready,
    input  in_ready, out_valid, out_bit, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_last, in_data, in_weight, threshold, out_ready,
    output in_ready, out_valid, out_bit, out_count, out_overflow
  );

endinterface

// File: rtl/xnor_neuron_accumulator_chunk_count.sv
// XNOR of one activation/weight chunk followed by a popcount.
//   data, weight : CHUNK_BITS-wide operands
//   count_c      : number of matching bit positions, 0..CHUNK_BITS (combinational)
module xnor_chunk_count #(
  parameter int unsigned CHUNK_BITS = 8
) (
  input  logic [CHUNK_BITS-1:0]         data,
  input  logic [CHUNK_BITS-1:0]         weight,
  output logic [$clog2(CHUNK_BITS+1)-1:0] count_c
);

  localparam int unsigned CNT_BITS = $clog2(CHUNK_BITS + 1);

  logic [CHUNK_BITS-1:0] match;

  // Matching bits are the binary-neuron "agreement" terms.
  always_comb begin
    match   = ~(data ^ weight);
    count_c = '0;
    for (int i = 0; i < int'(CHUNK_BITS); i++) begin
      count_c = count_c + CNT_BITS'(match[i]);
    end
  end

endmodule

// File: rtl/xnor_neuron_accumulator.sv
// Bit-serial binary neuron: accumulates XNOR-popcounts over a frame of chunk
// beats, then emits total > threshold plus the raw total and an overflow flag.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of xnor_neuron_accumulator_if (beat in, result out)
module xnor_neuron_accumulator
  import xnor_neuron_accumulator_pkg::*;
#(
  parameter int unsigned CHUNK_BITS = CHUNK_BITS_DEF,
  parameter int unsigned MAX_CHUNKS = MAX_CHUNKS_DEF
) (
  input logic                     clk,
  input logic                     reset,
  xnor_neuron_accumulator_if.slave bus
);

  localparam int unsigned ACC_BITS  = $clog2(CHUNK_BITS * MAX_CHUNKS + 1);
  localparam int unsigned SUM_BITS  = ACC_BITS + 1;
  localparam int unsigned CNT_BITS  = $clog2(CHUNK_BITS + 1);
  // Beat counter only needs to reach MAX_CHUNKS+1 to flag an over-long frame.
  localparam int unsigned BEAT_BITS = $clog2(MAX_CHUNKS + 2);
  localparam logic [BEAT_BITS-1:0] BEAT_CAP = BEAT_BITS'(MAX_CHUNKS + 1);
  localparam logic [BEAT_BITS-1:0] BEAT_MAX = BEAT_BITS'(MAX_CHUNKS);

  state_t                state;
  logic [ACC_BITS-1:0]   acc;
  logic [BEAT_BITS-1:0]  beats;
  logic                  sat_seen;

  logic [CNT_BITS-1:0]   chunk_count;
  logic [SUM_BITS-1:0]   sum_wide;
  logic [ACC_BITS-1:0]   sum_sat;
  logic                  sat_now;
  logic                  over_now;
  logic                  accept;

  xnor_chunk_count #(
    .CHUNK_BITS (CHUNK_BITS)
  ) u_chunk_count (
    .data    (bus.in_data),
    .weight  (bus.in_weight),
    .count_c (chunk_count)
  );

  // Ready in ACCUM; in HOLD only when the pending result is leaving this cycle.
  always_comb begin
    bus.in_ready = 1'b0;
    if (!reset) begin
      bus.in_ready = (state == ACCUM) ? 1'b1 : bus.out_ready;
    end
  end

  // Saturating add and frame status as seen with the current beat included.
  always_comb begin
    accept   = bus.in_valid && bus.in_ready;
    sum_wide = {1'b0, acc} + SUM_BITS'(chunk_count);
    sum_sat  = sum_wide[ACC_BITS] ? {ACC_BITS{1'b1}} : sum_wide[ACC_BITS-1:0];
    sat_now  = sat_seen || sum_wide[ACC_BITS];
    over_now = (beats >= BEAT_MAX);
  end

  // FSM, accumulator, beat counter and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ACCUM;
      acc              <= '0;
      beats            <= '0;
      sat_seen         <= 1'b0;
      bus.out_valid    <= 1'b0;
      bus.out_bit      <= 1'b0;
      bus.out_count    <= '0;
      bus.out_overflow <= 1'b0;
    end else begin
      if (state == HOLD && bus.out_ready) begin
        bus.out_valid <= 1'b0;
        state         <= ACCUM;
      end
      if (accept) begin
        if (bus.in_last) begin
          acc              <= '0;
          beats            <= '0;
          sat_seen         <= 1'b0;
          bus.out_count    <= sum_sat;
          bus.out_bit      <= (sum_sat > bus.threshold);
          bus.out_overflow <= over_now || sat_now;
          bus.out_valid    <= 1'b1;
          state            <= HOLD;
        end else begin
          acc      <= sum_sat;
          sat_seen <= sat_now;
          if (beats != BEAT_CAP) begin
            beats <= beats + BEAT_BITS'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_xnor_neuron_accumulator.sv
// Self-checking bench for xnor_neuron_accumulator: table-driven frames plus
// hand-written backpressure, zero-bubble, overflow and reset sequences.
// Expected results are queued when the last beat is driven and checked when
// the DUT hands the result over.
module tb_xnor_neuron_accumulator;
  import xnor_neuron_accumulator_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic [7:0] weight;
    logic       last;
    logic [7:0] thr;
    logic [7:0] exp_count;
    logic       exp_act;
    logic       exp_ovf;
  } vec_t;

  typedef struct {
    logic [7:0] count;
    logic       act;
    logic       ovf;
  } exp_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  exp_t sb[$];
  vec_t tab[8];

  xnor_neuron_accumulator_if #(.CHUNK_BITS(8), .ACC_BITS(8)) bus ();

  xnor_neuron_accumulator #(
    .CHUNK_BITS (8),
    .MAX_CHUNKS (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] c, input logic a, input logic o);
    exp_t e;
    e.count = c;
    e.act   = a;
    e.ovf   = o;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send_beat(input logic [7:0] d, input logic [7:0] w,
                           input logic l, input logic [7:0] thr);
    logic accepted;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_weight = w;
    bus.in_last   = l;
    bus.threshold = thr;
    accepted = 1'b0;
    for (int c = 0; c < 100 && !accepted; c++) begin
      @(negedge clk);
      if (bus.in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_accept: beat %0h/%0h never accepted", d, w);
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((sb.size() != 0 || bus.out_valid) && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (c >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d results still pending, out_valid=%0b", sb.size(), bus.out_valid);
    end
  endtask

  // Result scoreboard: one handshake per negedge with valid && ready.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: count=%0d bit=%0b ovf=%0b",
                 bus.out_count, bus.out_bit, bus.out_overflow);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_count", 32'(bus.out_count), 32'(e.count));
        check("out_bit", 32'(bus.out_bit), 32'(e.act));
        check("out_overflow", 32'(bus.out_overflow), 32'(e.ovf));
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    tab[0] = '{8'hFF, 8'hFF, 1'b1, 8'd7,  8'd8,  1'b1, 1'b0};
    tab[1] = '{8'h0F, 8'h00, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0};
    tab[2] = '{8'hAA, 8'hAA, 1'b1, 8'd12, 8'd12, 1'b0, 1'b0};
    tab[3] = '{8'h0F, 8'h00, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0};
    tab[4] = '{8'hAA, 8'hAA, 1'b1, 8'd11, 8'd12, 1'b1, 1'b0};
    tab[5] = '{8'h00, 8'hFF, 1'b1, 8'd0,  8'd0,  1'b0, 1'b0};
    tab[6] = '{8'h5A, 8'h0F, 1'b0, 8'd0,  8'd0,  1'b0, 1'b0};
    tab[7] = '{8'h12, 8'h34, 1'b1, 8'd5,  8'd9,  1'b1, 1'b0};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = '0;
    bus.in_weight = '0;
    bus.threshold = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_bit", 32'(bus.out_bit), 0);
    check("rst_out_count", 32'(bus.out_count), 0);
    check("rst_out_overflow", 32'(bus.out_overflow), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // Back-to-back frames from the table.
    foreach (tab[i]) begin
      if (tab[i].last) push_exp(tab[i].exp_count, tab[i].exp_act, tab[i].exp_ovf);
      send_beat(tab[i].data, tab[i].weight, tab[i].last, tab[i].thr);
    end
    // Exactly MAX_CHUNKS beats: not an overflow; 128 is not > 128.
    push_exp(8'd128, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) send_beat(8'hFF, 8'hFF, i == 15, 8'd128);
    drain();

    // One-cycle latency from accepted last beat to out_valid.
    push_exp(8'd8, 1'b1, 1'b0);
    send_beat(8'hFF, 8'hFF, 1'b1, 8'd7);
    check("latency_out_valid", 32'(bus.out_valid), 1);
    drain();

    // Backpressure: result held, pending beat not consumed.
    bus.out_ready = 1'b0;
    push_exp(8'd8, 1'b1, 1'b0);
    send_beat(8'hFF, 8'hFF, 1'b1, 8'd7);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h00;
    bus.in_weight = 8'h00;
    bus.in_last   = 1'b1;
    bus.threshold = 8'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_hold", {bus.out_valid, bus.out_bit, bus.out_overflow, bus.out_count},
            {1'b1, 1'b1, 1'b0, 8'd8});
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(bus.out_valid), 0);
    drain();

    // Zero-bubble: new single-beat frame accepted during the output handshake.
    bus.out_ready = 1'b0;
    push_exp(8'd8, 1'b1, 1'b0);
    send_beat(8'hFF, 8'hFF, 1'b1, 8'd7);
    bus.out_ready = 1'b1;
    push_exp(8'd0, 1'b0, 1'b0);
    send_beat(8'h00, 8'hFF, 1'b1, 8'd0);
    check("zb_valid_held", 32'(bus.out_valid), 1);
    check("zb_new_count", 32'(bus.out_count), 0);
    drain();

    // Over-long frame with accumulator saturation, then over-long only.
    push_exp(8'd255, 1'b1, 1'b1);
    for (int i = 0; i < 33; i++) send_beat(8'hFF, 8'hFF, i == 32, 8'd0);
    push_exp(8'd17, 1'b1, 1'b1);
    for (int i = 0; i < 17; i++) send_beat(8'h00, 8'hFE, i == 16, 8'd16);
    drain();

    // Reset mid-frame discards the partial sum.
    for (int i = 0; i < 3; i++) send_beat(8'hFF, 8'hFF, 1'b0, 8'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_outputs", {bus.out_valid, bus.out_bit, bus.out_overflow, bus.out_count}, 0);
    check("midrst_in_ready", 32'(bus.in_ready), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("postrst_outputs", {bus.out_valid, bus.out_bit, bus.out_overflow, bus.out_count}, 0);
    push_exp(8'd8, 1'b1, 1'b0);
    send_beat(8'h01, 8'h01, 1'b1, 8'd0);
    drain();

    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
